instr_fetch_unit: RTL and testbench

Instruction fetch front end that sits directly upstream of the single-cycle RISC-V core. It walks the program counter, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and buffers them with their PCs in a small prefetch FIFO. It presents them to the core over a valid/ready interface. A redirect from the core on a jump or taken branch flushes the FIFO and restarts fetch at the new target, discarding any in-flight word.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 41 ++++
 rtl/instr_fetch_unit.sv | 73 +++++++
 tb/tb_instr_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch front end
package fetch_pkg;
    localparam int WORD_LENGTH_DEFAULT = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef enum logic {RUN, DROP} fetch_state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO; flush wins over push and pop, head reads 0 when empty
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign do_pop = pop && count != '0;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign head = count != '0 ? mem[rd_ptr] : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC walker with req/ack imem fetch, prefetch FIFO and redirect flush
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int WORD_LENGTH = WORD_LENGTH_DEFAULT,
    parameter int FIFO_DEPTH = 2,
    parameter logic [WORD_LENGTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [WORD_LENGTH-1:0] imem_addr,
    input  logic                   imem_ack,
    input  logic [WORD_LENGTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [WORD_LENGTH-1:0] redirect_pc,
    output logic                   instr_valid,
    output logic [WORD_LENGTH-1:0] instr,
    output logic [WORD_LENGTH-1:0] instr_pc,
    input  logic                   instr_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WORD_LENGTH-1:0] START_PC = RESET_PC & ~WORD_LENGTH'(3);
    fetch_state_t state, state_d;
    logic [WORD_LENGTH-1:0] fetch_pc, pc_d, drop_addr, drop_addr_d, target;
    logic started, push, pop;
    logic [CW-1:0] count;
    fetch_entry_t entry_in, head;
    assign target = redirect_pc & ~WORD_LENGTH'(3);
    assign imem_req = started && (state == DROP || count < CW'(FIFO_DEPTH));
    // DROP keeps presenting the abandoned address until memory acks it
    assign imem_addr = state == DROP ? drop_addr : fetch_pc;
    assign push = state == RUN && imem_req && imem_ack && !redirect_valid;
    assign pop = instr_valid && instr_ready;
    assign entry_in = '{pc: fetch_pc, instr: imem_rdata};
    assign instr_valid = count != '0;
    assign instr = head.instr;
    assign instr_pc = head.pc;
    always_comb begin
        state_d = state;
        drop_addr_d = drop_addr;
        pc_d = redirect_valid ? target : push ? fetch_pc + WORD_LENGTH'(4) : fetch_pc;
        if (state == RUN && redirect_valid && imem_req && !imem_ack) begin
            state_d = DROP;
            drop_addr_d = fetch_pc;
        end else if (state == DROP && imem_ack) begin
            state_d = RUN;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            fetch_pc <= START_PC;
            drop_addr <= START_PC;
            started <= 1'b0;
        end else begin
            state <= state_d;
            fetch_pc <= pc_d;
            drop_addr <= drop_addr_d;
            started <= 1'b1;
        end
    end
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .push_data(entry_in),
        .pop(pop),
        .flush(redirect_valid),
        .count(count),
        .head(head)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized run against a queue-based model
module tb_instr_fetch_unit;
    logic clk = 0;
    logic reset = 1;
    logic imem_req, imem_ack = 0, redirect_valid = 0, instr_valid, instr_ready = 0;
    logic [31:0] imem_addr, imem_rdata, redirect_pc = 0, instr, instr_pc;
    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1357};
    endfunction

    assign imem_rdata = word_of(imem_addr);
    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 0;
        imem_ack = 0;
        instr_ready = 0;
        redirect_valid = 0;
        redirect_pc = 0;
        tick;
        tick;
        reset = 1;
    endtask

    task automatic test_reset;
        #3 reset = 0;
        #1;
        checks++;
        if ({imem_req, imem_addr, instr_valid, instr, instr_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_async: req=%0b addr=%h valid=%0b instr=%h pc=%h want all 0", imem_req, imem_addr, instr_valid, instr, instr_pc);
        end
        tick;
        tick;
        reset = 1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_not_started: req=%0b want 0", imem_req);
        end
        tick;
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_first_req: req=%0b addr=%h valid=%0b want 1 00000000 0", imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_stream;
        do_reset;
        imem_ack = 1;
        instr_ready = 1;
        tick;
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL stream_start: req=%0b addr=%h valid=%0b want 1 00000000 0", imem_req, imem_addr, instr_valid);
        end
        for (int i = 1; i <= 8; i++) begin
            tick;
            checks++;
            if ({imem_req, imem_addr, instr_valid, instr_pc, instr} !== {1'b1, 32'(4 * i), 1'b1, 32'(4 * (i - 1)), word_of(32'(4 * (i - 1)))}) begin
                errors++;
                $display("FAIL stream_%0d: req=%0b addr=%h valid=%0b pc=%h instr=%h want addr=%h pc=%h", i, imem_req, imem_addr, instr_valid, instr_pc, instr, 4 * i, 4 * (i - 1));
            end
        end
    endtask

    task automatic test_full;
        logic [31:0] got[$];
        do_reset;
        imem_ack = 1;
        instr_ready = 0;
        tick;
        tick;
        tick;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({imem_req, imem_addr, instr_valid, instr_pc} !== {1'b0, 32'h8, 1'b1, 32'h0}) begin
                errors++;
                $display("FAIL full_hold_%0d: req=%0b addr=%h valid=%0b pc=%h want 0 00000008 1 00000000", k, imem_req, imem_addr, instr_valid, instr_pc);
            end
            tick;
        end
        instr_ready = 1;
        for (int k = 0; k < 6; k++) begin
            if (instr_valid && instr_ready) got.push_back(instr_pc);
            if (k == 1) begin
                checks++;
                if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
                    errors++;
                    $display("FAIL full_rereq: req=%0b addr=%h want 1 00000008", imem_req, imem_addr);
                end
            end
            tick;
        end
        checks++;
        if (got.size() != 6) begin
            errors++;
            $display("FAIL full_count: delivered=%0d want 6", got.size());
        end
        foreach (got[i]) begin
            checks++;
            if (got[i] !== 32'(4 * i)) begin
                errors++;
                $display("FAIL full_order_%0d: pc=%h want %h", i, got[i], 4 * i);
            end
        end
    endtask

    task automatic test_delay;
        do_reset;
        imem_ack = 0;
        instr_ready = 1;
        tick;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
                errors++;
                $display("FAIL delay_wait_%0d: req=%0b addr=%h valid=%0b want 1 00000000 0", k, imem_req, imem_addr, instr_valid);
            end
            tick;
        end
        imem_ack = 1;
        tick;
        imem_ack = 0;
        checks++;
        if ({imem_req, imem_addr, instr_valid, instr_pc, instr} !== {1'b1, 32'h4, 1'b1, 32'h0, word_of(32'h0)}) begin
            errors++;
            $display("FAIL delay_data: req=%0b addr=%h valid=%0b pc=%h instr=%h want 1 00000004 1 00000000 %h", imem_req, imem_addr, instr_valid, instr_pc, instr, word_of(32'h0));
        end
    endtask

    task automatic test_redirect_drop;
        do_reset;
        imem_ack = 1;
        instr_ready = 1;
        tick;
        tick;
        tick;
        imem_ack = 0;
        redirect_valid = 1;
        redirect_pc = 32'h100;
        tick;
        redirect_valid = 0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h8, 1'b0}) begin
                errors++;
                $display("FAIL drop_hold_%0d: req=%0b addr=%h valid=%0b want 1 00000008 0", k, imem_req, imem_addr, instr_valid);
            end
            if (k == 0) tick;
        end
        imem_ack = 1;
        tick;
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL drop_target_req: req=%0b addr=%h valid=%0b want 1 00000100 0", imem_req, imem_addr, instr_valid);
        end
        tick;
        checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h100, word_of(32'h100)}) begin
            errors++;
            $display("FAIL drop_target_out: valid=%0b pc=%h instr=%h want 1 00000100 %h", instr_valid, instr_pc, instr, word_of(32'h100));
        end
    endtask

    task automatic test_redirect_ack;
        do_reset;
        imem_ack = 1;
        instr_ready = 1;
        tick;
        tick;
        tick;
        redirect_valid = 1;
        redirect_pc = 32'h203;
        tick;
        redirect_valid = 0;
        checks++;
        if ({imem_req, imem_addr, instr_valid, instr, instr_pc} !== {1'b1, 32'h200, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL redir_ack_flush: req=%0b addr=%h valid=%0b instr=%h pc=%h want 1 00000200 0 0 0", imem_req, imem_addr, instr_valid, instr, instr_pc);
        end
        tick;
        checks++;
        if ({instr_valid, instr_pc, instr, imem_addr} !== {1'b1, 32'h200, word_of(32'h200), 32'h204}) begin
            errors++;
            $display("FAIL redir_ack_out: valid=%0b pc=%h instr=%h addr=%h want 1 00000200 %h 00000204", instr_valid, instr_pc, instr, imem_addr, word_of(32'h200));
        end
    endtask

    task automatic test_reset_mid_drop;
        do_reset;
        imem_ack = 1;
        instr_ready = 1;
        tick;
        tick;
        imem_ack = 0;
        redirect_valid = 1;
        redirect_pc = 32'h40;
        tick;
        redirect_valid = 0;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin
            errors++;
            $display("FAIL mid_drop_setup: req=%0b addr=%h want 1 00000004", imem_req, imem_addr);
        end
        reset = 0;
        #1;
        checks++;
        if ({imem_req, imem_addr, instr_valid, instr, instr_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL mid_drop_async: req=%0b addr=%h valid=%0b instr=%h pc=%h want all 0", imem_req, imem_addr, instr_valid, instr, instr_pc);
        end
        tick;
        tick;
        imem_ack = 1;
        reset = 1;
        tick;
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL mid_drop_restart: req=%0b addr=%h valid=%0b want 1 00000000 0", imem_req, imem_addr, instr_valid);
        end
        tick;
        checks++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL mid_drop_first: valid=%0b pc=%h want 1 00000000", instr_valid, instr_pc);
        end
    endtask

    task automatic test_random;
        logic [63:0] q[$];
        logic started, dropping, exp_req;
        logic [31:0] pc, drop_addr, exp_addr;
        logic [63:0] exp_head;
        do_reset;
        started = 0;
        dropping = 0;
        pc = 0;
        drop_addr = 0;
        for (int c = 0; c < 600; c++) begin
            imem_ack = $urandom_range(0, 3) != 0;
            instr_ready = $urandom_range(0, 2) != 0;
            redirect_valid = $urandom_range(0, 9) == 0;
            redirect_pc = $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            exp_req = started && (dropping || q.size() < 2);
            exp_addr = dropping ? drop_addr : pc;
            exp_head = q.size() != 0 ? q[0] : 64'h0;
            checks++;
            if ({imem_req, imem_addr, instr_valid, instr_pc, instr} !== {exp_req, exp_addr, q.size() != 0, exp_head}) begin
                errors++;
                $display("FAIL random_%0d: req=%0b addr=%h valid=%0b pc=%h instr=%h want req=%0b addr=%h valid=%0b head=%h", c, imem_req, imem_addr, instr_valid, instr_pc, instr, exp_req, exp_addr, q.size() != 0, exp_head);
            end
            tick;
            if (redirect_valid) begin
                q.delete();
                if (!dropping && exp_req && !imem_ack) begin
                    dropping = 1;
                    drop_addr = pc;
                end else if (dropping && imem_ack) begin
                    dropping = 0;
                end
                pc = redirect_pc & ~32'h3;
            end else if (dropping) begin
                if (imem_ack) dropping = 0;
            end else begin
                if (q.size() != 0 && instr_ready) void'(q.pop_front());
                if (exp_req && imem_ack) begin
                    q.push_back({pc, word_of(pc)});
                    pc = pc + 32'h4;
                end
            end
            started = 1;
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_full;
        test_delay;
        test_redirect_drop;
        test_redirect_ack;
        test_reset_mid_drop;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
